// File: rtl/wire_out_status_snapshot_pkg.sv
// Shared definitions for the Wire Out status snapshot block: FSM encoding and widths.
package wire_out_status_snapshot_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        HOLD    = 2'd2
    } snap_state_t;

    localparam int COUNT_W = 32;
    localparam int SEQ_W   = 4;
    localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};

endpackage

// File: rtl/wire_out_status_snapshot_sat_counter.sv
// Saturating up-counter with synchronous clear; also exposes the value after this cycle's increment.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] value,
    output logic [W-1:0] value_inc
);

    logic [W-1:0] count_q;

    function automatic logic [W-1:0] sat_add(input logic [W-1:0] v, input logic en);
        if (en && (v != {W{1'b1}}))
            return v + W'(1);
        return v;
    endfunction

    // value_inc ignores clr so a capture on the same edge still sees the pre-clear total
    assign value_inc = sat_add(count_q, inc);
    assign value     = count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count_q <= '0;
        else if (clr)
            count_q <= '0;
        else
            count_q <= value_inc;
    end

endmodule

// File: rtl/wire_out_status_snapshot.sv
// Sticky event flags and event counter, captured on host request into a held three-word Wire Out image.
module wire_out_status_snapshot #(
    parameter int EVT_W         = 16,
    parameter int HOLD_CYCLES   = 8,
    parameter int CLEAR_ON_SNAP = 1
) (
    input  logic             ti_clk,
    input  logic             reset,
    input  logic [EVT_W-1:0] event_in,
    input  logic             cnt_en,
    input  logic             snap_req,
    input  logic             clr_req,
    output logic [15:0]      status_word,
    output logic [15:0]      count_lo,
    output logic [15:0]      count_hi,
    output logic             snap_busy,
    output logic             snap_done,
    output logic             snap_drop,
    output logic [3:0]       snap_seq
);
    import wire_out_status_snapshot_pkg::*;

    localparam int HOLD_W = $clog2(HOLD_CYCLES);

    snap_state_t          state, state_nxt;
    logic [HOLD_W-1:0]    hold_cnt;
    logic [EVT_W-1:0]     live_flags;
    logic [EVT_W-1:0]     flags_with_evt;
    logic [COUNT_W-1:0]   live_count;
    logic [COUNT_W-1:0]   count_with_evt;
    logic [SEQ_W-1:0]     seq_q;
    logic                 cnt_inc;
    logic                 capture;
    logic                 live_clr;
    logic                 hold_last;

    assign cnt_inc        = cnt_en & (|event_in);
    assign capture        = (state == CAPTURE);
    assign live_clr       = clr_req | (capture & (CLEAR_ON_SNAP != 0));
    assign flags_with_evt = live_flags | event_in;
    assign hold_last      = (state == HOLD) && (hold_cnt == HOLD_W'(HOLD_CYCLES - 1));

    sat_counter #(.W(COUNT_W)) u_live_cnt (
        .clk       (ti_clk),
        .rst       (reset),
        .inc       (cnt_inc),
        .clr       (live_clr),
        .value     (live_count),
        .value_inc (count_with_evt)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (snap_req) state_nxt = CAPTURE;
            CAPTURE: state_nxt = HOLD;
            HOLD:    if (hold_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ti_clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= (state == HOLD) ? hold_cnt + HOLD_W'(1) : '0;
        end
    end

    always_ff @(posedge ti_clk or posedge reset) begin
        if (reset)
            live_flags <= '0;
        else if (live_clr)
            live_flags <= '0;
        else
            live_flags <= flags_with_evt;
    end

    // Shadow image changes only on the capture edge; it includes the capture cycle's own events
    always_ff @(posedge ti_clk or posedge reset) begin
        if (reset) begin
            status_word <= '0;
            count_lo    <= '0;
            count_hi    <= '0;
        end else if (capture) begin
            status_word <= 16'(flags_with_evt);
            count_lo    <= count_with_evt[15:0];
            count_hi    <= count_with_evt[31:16];
        end
    end

    always_ff @(posedge ti_clk or posedge reset) begin
        if (reset) begin
            seq_q     <= '0;
            snap_drop <= 1'b0;
        end else begin
            snap_drop <= snap_req && (state != IDLE);
            if (snap_req && (state == IDLE))
                seq_q <= seq_q + SEQ_W'(1);
        end
    end

    assign snap_seq  = seq_q;
    assign snap_busy = (state != IDLE);
    assign snap_done = hold_last;

endmodule

// File: tb/tb_wire_out_status_snapshot.sv
// Directed bench for wire_out_status_snapshot with a cycle-level reference model.
module tb_wire_out_status_snapshot;

    localparam int EVT_W = 16;
    localparam int HOLD  = 8;
    localparam int CLRS  = 1;

    logic        ti_clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] event_in = '0;
    logic        cnt_en = 1'b0;
    logic        snap_req = 1'b0;
    logic        clr_req = 1'b0;
    logic [15:0] status_word, count_lo, count_hi;
    logic        snap_busy, snap_done, snap_drop;
    logic [3:0]  snap_seq;

    int checks = 0;
    int failures = 0;

    wire_out_status_snapshot #(
        .EVT_W(EVT_W), .HOLD_CYCLES(HOLD), .CLEAR_ON_SNAP(CLRS)
    ) dut (
        .ti_clk(ti_clk), .reset(reset), .event_in(event_in), .cnt_en(cnt_en),
        .snap_req(snap_req), .clr_req(clr_req), .status_word(status_word),
        .count_lo(count_lo), .count_hi(count_hi), .snap_busy(snap_busy),
        .snap_done(snap_done), .snap_drop(snap_drop), .snap_seq(snap_seq)
    );

    always #5 ti_clk = ~ti_clk;

    // Reference model: busy_left counts remaining busy cycles (capture cycle + HOLD cycles)
    logic [15:0] m_flags = '0;
    longint      m_count = 0;
    int          busy_left = 0;
    logic [15:0] e_status = '0;
    longint      e_count = 0;
    logic        e_drop = 1'b0;
    int          e_seq = 0;

    always @(posedge ti_clk or posedge reset) begin
        if (reset) begin
            m_flags = '0; m_count = 0; busy_left = 0;
            e_status = '0; e_count = 0; e_drop = 1'b0; e_seq = 0;
        end else begin : model_step
            bit     cap;
            longint after_inc;
            after_inc = m_count + ((cnt_en && event_in != 0) ? 1 : 0);
            if (after_inc > 64'h0000_0000_FFFF_FFFF) after_inc = 64'h0000_0000_FFFF_FFFF;
            cap = (busy_left == HOLD + 1);
            if (cap) begin
                e_status = m_flags | event_in;
                e_count  = after_inc;
            end
            if (clr_req || (cap && CLRS != 0)) begin
                m_flags = '0;
                m_count = 0;
            end else begin
                m_flags = m_flags | event_in;
                m_count = after_inc;
            end
            e_drop = snap_req && (busy_left > 0);
            if (busy_left > 0) busy_left = busy_left - 1;
            else if (snap_req) begin
                busy_left = HOLD + 1;
                e_seq = (e_seq + 1) % 16;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge ti_clk) begin
        check("m_busy",   32'(snap_busy),   32'(busy_left > 0));
        check("m_done",   32'(snap_done),   32'(busy_left == 1));
        check("m_drop",   32'(snap_drop),   32'(e_drop));
        check("m_seq",    32'(snap_seq),    32'(e_seq));
        check("m_status", 32'(status_word), 32'(e_status));
        check("m_lo",     32'(count_lo),    32'(e_count[15:0]));
        check("m_hi",     32'(count_hi),    32'(e_count[31:16]));
    end

    task automatic step(input logic [15:0] ev, input logic en, input logic sr, input logic cr);
        event_in = ev; cnt_en = en; snap_req = sr; clr_req = cr;
        @(negedge ti_clk);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 30 && snap_busy; i++) step(16'h0, 1'b0, 1'b0, 1'b0);
        check("idle_reached", 32'(snap_busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        #1 reset = 1'b1;
        repeat (3) @(negedge ti_clk);
        reset = 1'b0;
        repeat (20) step(16'h0, 1'b0, 1'b0, 1'b0);
        check("rst_status", 32'(status_word), 32'h0);
        check("rst_lo",     32'(count_lo),    32'h0);
        check("rst_hi",     32'(count_hi),    32'h0);
        check("rst_seq",    32'(snap_seq),    32'h0);
        check("rst_busy",   32'(snap_busy),   32'h0);

        // basic snapshot, then a rejected request three cycles later
        step(16'h0005, 1'b1, 1'b0, 1'b0);
        step(16'h0100, 1'b1, 1'b0, 1'b0);
        step(16'h0000, 1'b1, 1'b1, 1'b0);
        step(16'h0000, 1'b1, 1'b0, 1'b0);
        check("snap1_status", 32'(status_word), 32'h0105);
        check("snap1_lo",     32'(count_lo),    32'h2);
        check("snap1_hi",     32'(count_hi),    32'h0);
        check("snap1_seq",    32'(snap_seq),    32'h1);
        step(16'h0000, 1'b1, 1'b0, 1'b0);
        step(16'h0000, 1'b1, 1'b1, 1'b0);
        check("drop_pulse",  32'(snap_drop),   32'h1);
        check("drop_seq",    32'(snap_seq),    32'h1);
        check("drop_status", 32'(status_word), 32'h0105);
        wait_idle();

        // event in the capture cycle lands in the shadow, not the next interval
        step(16'h0000, 1'b1, 1'b1, 1'b0);
        step(16'h8000, 1'b1, 1'b0, 1'b0);
        check("capevt_status", 32'(status_word), 32'h8000);
        check("capevt_lo",     32'(count_lo),    32'h1);
        wait_idle();
        step(16'h0000, 1'b1, 1'b1, 1'b0);
        step(16'h0000, 1'b1, 1'b0, 1'b0);
        check("empty_status", 32'(status_word), 32'h0);
        check("empty_lo",     32'(count_lo),    32'h0);
        wait_idle();

        // clr_req beats a same-cycle event
        step(16'h0003, 1'b1, 1'b0, 1'b0);
        step(16'h0010, 1'b1, 1'b0, 1'b1);
        step(16'h0020, 1'b1, 1'b0, 1'b0);
        step(16'h0000, 1'b1, 1'b1, 1'b0);
        step(16'h0000, 1'b1, 1'b0, 1'b0);
        check("clr_status", 32'(status_word), 32'h0020);
        check("clr_lo",     32'(count_lo),    32'h1);
        wait_idle();

        // clr_req during capture keeps pre-clear value plus events
        step(16'h0040, 1'b1, 1'b0, 1'b0);
        step(16'h0000, 1'b1, 1'b1, 1'b0);
        step(16'h0080, 1'b1, 1'b0, 1'b1);
        check("clrcap_status", 32'(status_word), 32'h00C0);
        check("clrcap_lo",     32'(count_lo),    32'h2);
        wait_idle();

        // snap_req + clr_req together in IDLE
        step(16'h0001, 1'b1, 1'b0, 1'b0);
        step(16'h0002, 1'b1, 1'b1, 1'b1);
        step(16'h0004, 1'b1, 1'b0, 1'b0);
        check("snapclr_status", 32'(status_word), 32'h0004);
        check("snapclr_lo",     32'(count_lo),    32'h1);
        wait_idle();

        // saturation from a preloaded counter
        force dut.u_live_cnt.count_q = 32'hFFFF_FFFE;
        m_count = 64'h0000_0000_FFFF_FFFE;
        step(16'h0000, 1'b0, 1'b0, 1'b0);
        release dut.u_live_cnt.count_q;
        repeat (5) step(16'h0200, 1'b1, 1'b0, 1'b0);
        step(16'h0000, 1'b1, 1'b1, 1'b0);
        step(16'h0001, 1'b1, 1'b0, 1'b0);
        check("sat_lo",     32'(count_lo),    32'hFFFF);
        check("sat_hi",     32'(count_hi),    32'hFFFF);
        check("sat_status", 32'(status_word), 32'h0201);
        wait_idle();

        // asynchronous reset in the middle of HOLD
        step(16'h0000, 1'b1, 1'b1, 1'b0);
        step(16'h0000, 1'b1, 1'b0, 1'b0);
        step(16'h0000, 1'b1, 1'b0, 1'b0);
        step(16'h0000, 1'b1, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        check("midrst_busy",   32'(snap_busy),   32'h0);
        check("midrst_done",   32'(snap_done),   32'h0);
        check("midrst_status", 32'(status_word), 32'h0);
        check("midrst_lo",     32'(count_lo),    32'h0);
        check("midrst_hi",     32'(count_hi),    32'h0);
        check("midrst_seq",    32'(snap_seq),    32'h0);
        repeat (2) @(negedge ti_clk);
        reset = 1'b0;
        repeat (10) step(16'h0000, 1'b0, 1'b0, 1'b0);
        step(16'h0009, 1'b1, 1'b0, 1'b0);
        step(16'h0000, 1'b1, 1'b1, 1'b0);
        step(16'h0000, 1'b1, 1'b0, 1'b0);
        check("postrst_seq",    32'(snap_seq),    32'h1);
        check("postrst_status", 32'(status_word), 32'h0009);
        check("postrst_lo",     32'(count_lo),    32'h1);
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wire_out_status_snapshot.md
Name: wire_out_status_snapshot

Overview:
- Upstream producer for the host Wire Out endpoints. It accumulates sticky event flags and a 32-bit event counter in the user logic.
- On a host snapshot request (Trigger In pulse) it captures a coherent three-word image into shadow registers. These drive ep_datain of three okWireOut instances (status, count_lo, count_hi).
- Shadow words stay stable for a guard window, so a host wire update never samples a half-updated image.

Parameters:
- EVT_W, 16, number of event inputs; equals status word width (1..16).
- HOLD_CYCLES, 8, minimum cycles the shadow image is held before another snapshot may be accepted (>=2).
- CLEAR_ON_SNAP, 1, 1 = live sticky flags and counter clear on capture; 0 = they persist.

Ports:
- ti_clk  in  1  host-interface clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- event_in  in  EVT_W  single-cycle event pulses, one per bit.
- cnt_en  in  1  when high, each cycle with any event_in bit set increments the counter by 1.
- snap_req  in  1  one-cycle snapshot request from a Trigger In.
- clr_req  in  1  one-cycle clear of live flags and counter.
- status_word  out  16  shadow sticky flags, zero-extended above EVT_W; feeds okWireOut ep_datain.
- count_lo  out  16  shadow counter [15:0].
- count_hi  out  16  shadow counter [31:16].
- snap_busy  out  1  high while in CAPTURE or HOLD.
- snap_done  out  1  one-cycle pulse when HOLD ends.
- snap_drop  out  1  one-cycle pulse when a snap_req is rejected because the block is busy.
- snap_seq  out  4  count of accepted snapshots, wraps 15->0.

Behaviour:
- Reset:
  - All outputs are 0; FSM enters IDLE.
  - Live flags, live counter and hold counter are 0.
  - Reset mid-HOLD aborts the hold with no snap_done.
- Live sticky flags: flag[i] <= flag[i] | event_in[i] each cycle.
- Live counter:
  - 32-bit; increments when cnt_en && |event_in.
  - Saturates at 0xFFFF_FFFF with no wrap.
- FSM states: IDLE, CAPTURE, HOLD.
- IDLE:
  - snap_req -> CAPTURE next cycle.
  - snap_seq increments on acceptance.
- CAPTURE (exactly 1 cycle):
  - Shadow regs load the live flags/counter values *including* this cycle's events, i.e. flags | event_in and counter + increment.
  - If CLEAR_ON_SNAP=1, live regs reload with 0 on the same edge; events in the capture cycle therefore appear in the shadow, not in the next live interval, so no event is lost or double-counted.
  - Next state is HOLD, hold counter = 0.
- HOLD:
  - Hold counter increments.
  - When it reaches HOLD_CYCLES-1: snap_done pulses that cycle and the FSM returns to IDLE.
- Outputs: shadow outputs change only on the CAPTURE edge; latency snap_req -> new shadow visible = 2 edges.
- snap_busy = (state != IDLE).
- Busy rejection: snap_req while busy -> request ignored, snap_drop pulses the next cycle, snap_seq unchanged.
- clr_req:
  - Clears live flags/counter; clr_req takes priority over same-cycle events.
  - clr_req coincident with CAPTURE: the shadow still captures the pre-clear value plus events, and live goes to 0.
  - clr_req never alters shadow outputs.
- snap_req and clr_req in IDLE on the same cycle: the snapshot is accepted; the clear applies to live regs on that edge. The captured image is therefore the post-clear live value from the next cycle, i.e. only events arriving in the CAPTURE cycle.
- Width rules: status_word[15:EVT_W] = 0. Counter increment is 1 per cycle regardless of how many event bits are set.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'd0, CAPTURE=2'd1, HOLD=2'd2), COUNT_W=32, SEQ_W=4, and the saturate-max constant.
- One sub-module: sat_counter (parameterised width; inc, clr, saturating; async reset) used for the live counter. Hold counter stays inline.

Test Plan:
- Reset release, no stimulus -> all outputs 0, snap_busy=0 for 20 cycles.
- event_in=0x0005 for 1 cycle, 0x0100 for 1 cycle, cnt_en=1, then snap_req -> after 2 edges status_word=0x0105, count_lo=2, count_hi=0, snap_seq=1, snap_done after HOLD_CYCLES=8 further cycles.
- snap_req with event_in=0x8000 arriving in the CAPTURE cycle, CLEAR_ON_SNAP=1 -> shadow status bit15=1; the next snapshot with no events gives status_word=0, count=0.
- Second snap_req 3 cycles after the first -> snap_drop pulse, snap_seq stays 1, shadow unchanged.
- Counter preloaded near 0xFFFF_FFFE (force via 2^32-2 events or a backdoor), 5 more events -> snapshot gives count_hi=0xFFFF, count_lo=0xFFFF.
- Assert reset during HOLD -> outputs 0 immediately (async), no snap_done; after release, snap_req operates normally with snap_seq=1.
